super_i3_bch_inner_syndrome_dispatch: RTL and testbench



---
 rtl/super_i3_bch_inner_syndrome_dispatch_pkg.sv | 15 +
 rtl/super_i3_bch_inner_syndrome_slot.sv | 86 ++++++++
 rtl/super_i3_bch_inner_syndrome_dispatch.sv | 182 ++++++++++++++++++
 tb/tb_super_i3_bch_inner_syndrome_dispatch.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/super_i3_bch_inner_syndrome_dispatch_pkg.sv
// Shared types for the I.3 inner BCH syndrome path: GF symbol, per-decoder
// syndrome vector, per-frame syndrome bank and decoder index.
package super_i3_bch_inner_syndrome_dispatch_pkg;

    localparam int unsigned cDEC_NUM = 16;
    localparam int unsigned cT2      = 20;
    localparam int unsigned cM       = 11;
    localparam int unsigned cIDX_W   = $clog2(cDEC_NUM);

    typedef logic [cM-1:0]               gf_dat_t;
    typedef gf_dat_t [1:cT2]             dec_syn_t;
    typedef dec_syn_t [cDEC_NUM-1:0]     syn_bank_t;
    typedef logic [cIDX_W-1:0]           dec_idx_t;

endpackage

// File: rtl/super_i3_bch_inner_syndrome_slot.sv
// Two-entry syndrome bank store: write/read slot pointers, per-slot valid flags,
// per-decoder zero flags computed at capture, and a combinational read port.
module super_i3_bch_inner_syndrome_slot
    import super_i3_bch_inner_syndrome_dispatch_pkg::*;
#(
    parameter int unsigned pDEC_NUM = cDEC_NUM,
    parameter int unsigned pT2      = cT2,
    parameter int unsigned pM       = cM,
    localparam int unsigned IDX_W   = (pDEC_NUM > 1) ? $clog2(pDEC_NUM) : 1
) (
    input  logic                               iclk,
    input  logic                               ireset,
    input  logic                               iclkena,
    input  logic                               wr_en,
    input  logic [pDEC_NUM-1:0][1:pT2][pM-1:0] wr_bank,
    input  logic                               wr_ptr,
    input  logic                               rel,
    input  logic                               rd_sel,
    input  logic [IDX_W-1:0]                   rd_idx,
    output logic [1:0]                         valid,
    output logic                               wr,
    output logic                               rd,
    output logic                               full_nxt_c,
    output logic                               wr_zero0_c,
    output logic [1:pT2][pM-1:0]               rd_syn_c,
    output logic                               rd_zero_c,
    output logic                               rd_ptr_c
);

    logic [pDEC_NUM-1:0][1:pT2][pM-1:0] bank [2];
    logic [pDEC_NUM-1:0]                zero [2];
    logic [1:0]                         ptr;
    logic [pDEC_NUM-1:0]                in_zero;
    logic [1:0]                         valid_nxt;

    // NOR over every syndrome of each decoder, before it is stored
    always_comb begin
        in_zero = '0;
        for (int unsigned d = 0; d < pDEC_NUM; d++) begin
            in_zero[d] = ~|wr_bank[d];
        end
    end

    // a write into the slot being released in the same cycle leaves it valid
    always_comb begin
        valid_nxt = valid;
        if (rel) begin
            valid_nxt[rd] = 1'b0;
        end
        if (wr_en) begin
            valid_nxt[wr] = 1'b1;
        end
    end

    assign full_nxt_c = &valid_nxt;
    assign wr_zero0_c = in_zero[0];

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            valid <= 2'b00;
            wr    <= 1'b0;
            rd    <= 1'b0;
        end else if (iclkena) begin
            valid <= valid_nxt;
            if (rel) begin
                rd <= ~rd;
            end
            if (wr_en) begin
                wr <= ~wr;
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (iclkena && wr_en) begin
            bank[wr] <= wr_bank;
            zero[wr] <= in_zero;
            ptr[wr]  <= wr_ptr;
        end
    end

    assign rd_syn_c  = bank[rd_sel][rd_idx];
    assign rd_zero_c = zero[rd_sel][rd_idx];
    assign rd_ptr_c  = ptr[rd_sel];

endmodule

// File: rtl/super_i3_bch_inner_syndrome_dispatch.sv
// Ping-pong buffers per-frame inner BCH syndrome banks and serializes them, one
// decoder per beat, onto a valid/ready stream for the shared key-equation solver.
module super_i3_bch_inner_syndrome_dispatch
    import super_i3_bch_inner_syndrome_dispatch_pkg::*;
#(
    parameter int unsigned pDEC_NUM = cDEC_NUM,
    parameter int unsigned pT2      = cT2,
    parameter int unsigned pM       = cM,
    localparam int unsigned IDX_W   = (pDEC_NUM > 1) ? $clog2(pDEC_NUM) : 1
) (
    input  logic                               iclk,
    input  logic                               ireset,
    input  logic                               iclkena,
    input  logic                               isyndrome_val,
    input  logic                               isyndrome_ptr,
    input  logic [pDEC_NUM-1:0][1:pT2][pM-1:0] isyndrome,
    output logic                               oval,
    input  logic                               iready,
    output logic                               osop,
    output logic                               oeop,
    output logic [IDX_W-1:0]                   odec_idx,
    output logic                               optr,
    output logic                               ozero,
    output logic [1:pT2][pM-1:0]               osyndrome,
    output logic                               obusy,
    output logic                               oovf
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(pDEC_NUM - 1);

    logic [0:0]             state, state_nxt;
    logic [1:0]             valid;
    logic                   wr, rd, rd_other;
    logic                   full_nxt_c, wr_zero0_c;
    logic [1:pT2][pM-1:0]   rd_syn_c;
    logic                   rd_zero_c, rd_ptr_c;
    logic                   last_beat, wr_en, ovf_set, other_written, other_ready;
    logic                   load_sel;
    logic [IDX_W-1:0]       load_idx;
    logic                   load, bypass;
    logic                   val_nxt, sop_nxt, eop_nxt, ptr_nxt, zero_nxt;
    logic [IDX_W-1:0]       idx_nxt;
    logic [1:pT2][pM-1:0]   syn_nxt;

    assign rd_other      = ~rd;
    assign last_beat     = (state == ST_SEND) & oval & iready & (odec_idx == LAST_IDX);
    assign wr_en         = isyndrome_val & iclkena & (~(valid[0] & valid[1]) | last_beat);
    assign ovf_set       = isyndrome_val & iclkena & ~wr_en;
    assign other_written = wr_en & (wr == rd_other);
    assign other_ready   = valid[rd_other] | other_written;
    assign bypass        = last_beat & other_written;

    super_i3_bch_inner_syndrome_slot #(
        .pDEC_NUM (pDEC_NUM),
        .pT2      (pT2),
        .pM       (pM)
    ) u_slot (
        .iclk       (iclk),
        .ireset     (ireset),
        .iclkena    (iclkena),
        .wr_en      (wr_en),
        .wr_bank    (isyndrome),
        .wr_ptr     (isyndrome_ptr),
        .rel        (last_beat & iclkena),
        .rd_sel     (load_sel),
        .rd_idx     (load_idx),
        .valid      (valid),
        .wr         (wr),
        .rd         (rd),
        .full_nxt_c (full_nxt_c),
        .wr_zero0_c (wr_zero0_c),
        .rd_syn_c   (rd_syn_c),
        .rd_zero_c  (rd_zero_c),
        .rd_ptr_c   (rd_ptr_c)
    );

    // read address for the beat to be loaded: next decoder, or decoder 0 of the other slot
    always_comb begin
        load_sel = rd;
        load_idx = '0;
        if (state == ST_SEND) begin
            if (last_beat) begin
                load_sel = rd_other;
            end else begin
                load_idx = odec_idx + IDX_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        val_nxt   = oval;
        sop_nxt   = osop;
        eop_nxt   = oeop;
        idx_nxt   = odec_idx;
        ptr_nxt   = optr;
        zero_nxt  = ozero;
        syn_nxt   = osyndrome;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (valid[rd]) begin
                    load      = 1'b1;
                    val_nxt   = 1'b1;
                    sop_nxt   = 1'b1;
                    eop_nxt   = (pDEC_NUM == 1);
                    idx_nxt   = '0;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (oval && iready) begin
                    if (!last_beat) begin
                        load    = 1'b1;
                        idx_nxt = load_idx;
                        sop_nxt = 1'b0;
                        eop_nxt = (load_idx == LAST_IDX);
                    end else if (other_ready) begin
                        load    = 1'b1;
                        idx_nxt = '0;
                        sop_nxt = 1'b1;
                        eop_nxt = (pDEC_NUM == 1);
                    end else begin
                        val_nxt   = 1'b0;
                        sop_nxt   = 1'b0;
                        eop_nxt   = 1'b0;
                        idx_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // a bank captured this very cycle is not in the store yet; take it from the port
        if (load) begin
            if (bypass) begin
                ptr_nxt  = isyndrome_ptr;
                zero_nxt = wr_zero0_c;
                syn_nxt  = isyndrome[0];
            end else begin
                ptr_nxt  = rd_ptr_c;
                zero_nxt = rd_zero_c;
                syn_nxt  = rd_syn_c;
            end
        end
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state <= ST_IDLE;
        end else if (iclkena) begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            oval      <= 1'b0;
            osop      <= 1'b0;
            oeop      <= 1'b0;
            odec_idx  <= '0;
            optr      <= 1'b0;
            ozero     <= 1'b0;
            osyndrome <= '0;
            obusy     <= 1'b0;
            oovf      <= 1'b0;
        end else if (iclkena) begin
            oval      <= val_nxt;
            osop      <= sop_nxt;
            oeop      <= eop_nxt;
            odec_idx  <= idx_nxt;
            optr      <= ptr_nxt;
            ozero     <= zero_nxt;
            osyndrome <= syn_nxt;
            obusy     <= full_nxt_c;
            oovf      <= oovf | ovf_set;
        end
    end

endmodule

// File: tb/tb_super_i3_bch_inner_syndrome_dispatch.sv
// Bench for the syndrome dispatcher: a frame-queue reference model predicts every
// accepted beat; each scenario task checks the stream against it.
module tb_super_i3_bch_inner_syndrome_dispatch;
    import super_i3_bch_inner_syndrome_dispatch_pkg::*;

    localparam int unsigned DN = cDEC_NUM;

    typedef struct packed {
        dec_idx_t idx;
        logic     sop;
        logic     eop;
        logic     ptr;
        logic     zero;
        dec_syn_t syn;
    } beat_t;

    logic      iclk = 1'b0;
    logic      ireset, iclkena, isyndrome_val, isyndrome_ptr, iready;
    syn_bank_t isyndrome;
    logic      oval, osop, oeop, optr, ozero, obusy, oovf;
    dec_idx_t  odec_idx;
    dec_syn_t  osyndrome;

    int compared   = 0;
    int mismatched = 0;

    // reference model: frames accepted but not yet fully emitted, and next decoder index
    syn_bank_t fq_bank[$];
    logic      fq_ptr[$];
    int        k       = 0;
    logic      ovf_exp = 1'b0;

    always #5 iclk = ~iclk;

    super_i3_bch_inner_syndrome_dispatch dut (
        .iclk          (iclk),
        .ireset        (ireset),
        .iclkena       (iclkena),
        .isyndrome_val (isyndrome_val),
        .isyndrome_ptr (isyndrome_ptr),
        .isyndrome     (isyndrome),
        .oval          (oval),
        .iready        (iready),
        .osop          (osop),
        .oeop          (oeop),
        .odec_idx      (odec_idx),
        .optr          (optr),
        .ozero         (ozero),
        .osyndrome     (osyndrome),
        .obusy         (obusy),
        .oovf          (oovf)
    );

    function automatic syn_bank_t rand_bank(input logic [DN-1:0] zmask);
        syn_bank_t b;
        for (int d = 0; d < DN; d++) begin
            for (int t = 1; t <= cT2; t++) begin
                b[d][t] = zmask[d] ? '0 : gf_dat_t'($urandom);
            end
            if (!zmask[d]) b[d][1][0] = 1'b1;
        end
        return b;
    endfunction

    function automatic beat_t exp_beat();
        beat_t    e;
        dec_syn_t s;
        if (fq_ptr.size() == 0) return '0;
        s      = fq_bank[0][k];
        e.idx  = dec_idx_t'(k);
        e.sop  = (k == 0);
        e.eop  = (k == DN - 1);
        e.ptr  = fq_ptr[0];
        e.zero = (s == '0);
        e.syn  = s;
        return e;
    endfunction

    function automatic beat_t obs_beat();
        return {odec_idx, osop, oeop, optr, ozero, osyndrome};
    endfunction

    // one clock of stimulus; the model advances by the spec's handshake and full rules
    task automatic tick(input logic sv, input logic p, input syn_bank_t b, input logic rdy);
        logic hs, last, acc;
        hs   = oval & rdy & iclkena;
        last = hs && (k == DN - 1);
        acc  = sv && iclkena && (fq_ptr.size() < 2 || last);
        iready        = rdy;
        isyndrome_val = sv;
        isyndrome_ptr = p;
        isyndrome     = b;
        @(posedge iclk);
        #1;
        isyndrome_val = 1'b0;
        if (hs && fq_ptr.size() > 0) begin
            k++;
            if (k == DN) begin
                k = 0;
                fq_bank.delete(0);
                fq_ptr.delete(0);
            end
        end
        if (acc) begin
            fq_bank.push_back(b);
            fq_ptr.push_back(p);
        end else if (sv && iclkena) begin
            ovf_exp = 1'b1;
        end
    endtask

    task automatic test_reset();
        ireset = 1'b1; iclkena = 1'b1; isyndrome_val = 1'b0; isyndrome_ptr = 1'b0;
        isyndrome = '0; iready = 1'b0;
        repeat (3) @(posedge iclk);
        #1;
        compared++;
        if (oval !== 1'b0) begin mismatched++; $display("FAIL reset_oval: got %b want 0", oval); end
        compared++;
        if (obs_beat() !== '0) begin mismatched++; $display("FAIL reset_beat: got %h want 0", obs_beat()); end
        compared++;
        if ({obusy, oovf} !== 2'b00) begin mismatched++; $display("FAIL reset_flags: got %b want 00", {obusy, oovf}); end
        ireset = 1'b0;
        tick(1'b0, 1'b0, '0, 1'b1);
        compared++;
        if (oval !== 1'b0) begin mismatched++; $display("FAIL reset_idle: got oval=%b want 0", oval); end
    endtask

    task automatic test_single_frame();
        syn_bank_t b;
        for (int d = 0; d < DN; d++)
            for (int t = 1; t <= cT2; t++) b[d][t] = gf_dat_t'(d * 32 + t);
        tick(1'b1, 1'b1, b, 1'b1);
        compared++;
        if (oval !== 1'b0) begin mismatched++; $display("FAIL single_c1: got oval=%b want 0", oval); end
        tick(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < DN; i++) begin
            compared++;
            if (oval !== 1'b1 || obs_beat() !== exp_beat())
                begin mismatched++; $display("FAIL single_beat%0d: got val=%b %h want %h", i, oval, obs_beat(), exp_beat()); end
            tick(1'b0, 1'b0, '0, 1'b1);
        end
        compared++;
        if (oval !== 1'b0 || fq_ptr.size() != 0)
            begin mismatched++; $display("FAIL single_tail: got oval=%b pending=%0d want 0/0", oval, fq_ptr.size()); end
    endtask

    task automatic test_zero_detect();
        syn_bank_t b;
        int nz = 0;
        b = rand_bank(DN'((1 << 3) | (1 << 7)));
        tick(1'b1, 1'(($urandom)), b, 1'b1);
        tick(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < DN; i++) begin
            compared++;
            if (oval !== 1'b1 || obs_beat() !== exp_beat())
                begin mismatched++; $display("FAIL zero_beat%0d: got val=%b %h want %h", i, oval, obs_beat(), exp_beat()); end
            if (ozero === 1'b1) nz++;
            tick(1'b0, 1'b0, '0, 1'b1);
        end
        compared++;
        if (nz != 2) begin mismatched++; $display("FAIL zero_count: got %0d want 2", nz); end
    endtask

    task automatic test_backpressure();
        beat_t prev = '0;
        logic  prev_stall = 1'b0;
        logic  rdy;
        int    acc = 0;
        tick(1'b1, 1'(($urandom)), rand_bank('0), 1'b0);
        for (int cyc = 0; cyc < 400 && fq_ptr.size() != 0; cyc++) begin
            rdy = 1'($urandom % 2);
            if (oval === 1'b1) begin
                compared++;
                if (obs_beat() !== exp_beat())
                    begin mismatched++; $display("FAIL bp_beat: got %h want %h", obs_beat(), exp_beat()); end
                if (prev_stall) begin
                    compared++;
                    if (obs_beat() !== prev)
                        begin mismatched++; $display("FAIL bp_hold: got %h want %h", obs_beat(), prev); end
                end
                prev = obs_beat();
            end
            prev_stall = (oval === 1'b1) && !rdy;
            if (oval === 1'b1 && rdy) acc++;
            tick(1'b0, 1'b0, '0, rdy);
        end
        compared++;
        if (acc != DN || fq_ptr.size() != 0)
            begin mismatched++; $display("FAIL bp_count: got %0d beats pending=%0d want %0d/0", acc, fq_ptr.size(), DN); end
    endtask

    task automatic test_back_to_back();
        syn_bank_t ba, bb, bc;
        logic sv, p;
        ba = rand_bank('0); bb = rand_bank('0); bc = rand_bank('0);
        tick(1'b1, 1'b0, ba, 1'b1);
        tick(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3 * DN; i++) begin
            compared++;
            if (oval !== 1'b1 || obs_beat() !== exp_beat())
                begin mismatched++; $display("FAIL b2b_beat%0d: got val=%b %h want %h", i, oval, obs_beat(), exp_beat()); end
            // second frame mid-emission; third lands on the last-beat handshake with both slots full
            sv = (i == 5) || (i == DN - 1);
            p  = (i == 5);
            tick(sv, p, (i == 5) ? bb : bc, 1'b1);
        end
        compared++;
        if (oval !== 1'b0 || fq_ptr.size() != 0)
            begin mismatched++; $display("FAIL b2b_tail: got oval=%b pending=%0d want 0/0", oval, fq_ptr.size()); end
    endtask

    task automatic test_clkena();
        beat_t hold;
        int    nb = 0;
        tick(1'b1, 1'b1, rand_bank('0), 1'b1);
        tick(1'b0, 1'b0, '0, 1'b1);
        repeat (3) tick(1'b0, 1'b0, '0, 1'b1);
        hold = obs_beat();
        iclkena = 1'b0;
        repeat (4) begin
            tick(1'b1, 1'b0, rand_bank('0), 1'b1);
            compared++;
            if (oval !== 1'b1 || obs_beat() !== hold)
                begin mismatched++; $display("FAIL ena_hold: got val=%b %h want %h", oval, obs_beat(), hold); end
        end
        iclkena = 1'b1;
        for (int cyc = 0; cyc < 100 && fq_ptr.size() != 0; cyc++) begin
            if (oval === 1'b1) begin
                compared++;
                if (obs_beat() !== exp_beat())
                    begin mismatched++; $display("FAIL ena_beat: got %h want %h", obs_beat(), exp_beat()); end
                nb++;
            end
            tick(1'b0, 1'b0, '0, 1'b1);
        end
        repeat (3) begin
            compared++;
            if (oval !== 1'b0) begin mismatched++; $display("FAIL ena_extra: got oval=%b want 0", oval); end
            tick(1'b0, 1'b0, '0, 1'b1);
        end
        compared++;
        if (nb != DN - 3) begin mismatched++; $display("FAIL ena_count: got %0d want %0d", nb, DN - 3); end
    endtask

    task automatic test_overflow();
        int nb = 0;
        tick(1'b1, 1'b0, rand_bank('0), 1'b0);
        tick(1'b0, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b1, rand_bank('0), 1'b0);
        compared++;
        if (obusy !== 1'b1) begin mismatched++; $display("FAIL ovf_busy: got %b want 1", obusy); end
        compared++;
        if (oovf !== 1'b0) begin mismatched++; $display("FAIL ovf_early: got %b want 0", oovf); end
        tick(1'b0, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b0, rand_bank(DN'(16'h00ff)), 1'b0);
        repeat (3) begin
            compared++;
            if (oovf !== ovf_exp) begin mismatched++; $display("FAIL ovf_sticky: got %b want %b", oovf, ovf_exp); end
            tick(1'b0, 1'b0, '0, 1'b0);
        end
        for (int cyc = 0; cyc < 200 && fq_ptr.size() != 0; cyc++) begin
            if (oval === 1'b1) begin
                compared++;
                if (obs_beat() !== exp_beat())
                    begin mismatched++; $display("FAIL ovf_beat: got %h want %h", obs_beat(), exp_beat()); end
                nb++;
            end
            tick(1'b0, 1'b0, '0, 1'b1);
        end
        repeat (3) begin
            compared++;
            if (oval !== 1'b0) begin mismatched++; $display("FAIL ovf_extra: got oval=%b want 0", oval); end
            tick(1'b0, 1'b0, '0, 1'b1);
        end
        compared++;
        if (nb != 2 * DN) begin mismatched++; $display("FAIL ovf_count: got %0d want %0d", nb, 2 * DN); end
        compared++;
        if ({oovf, obusy} !== {ovf_exp, 1'b0})
            begin mismatched++; $display("FAIL ovf_end: got ovf=%b busy=%b want %b/0", oovf, obusy, ovf_exp); end
    endtask

    task automatic test_reset_mid();
        int nb = 0;
        tick(1'b1, 1'b1, rand_bank('0), 1'b1);
        tick(1'b1, 1'b0, rand_bank('0), 1'b1);
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (oval === 1'b1 && odec_idx === dec_idx_t'(5)) break;
            tick(1'b0, 1'b0, '0, 1'b1);
        end
        compared++;
        if (oval !== 1'b1 || odec_idx !== dec_idx_t'(5))
            begin mismatched++; $display("FAIL rst_reach: got val=%b idx=%0d want 1/5", oval, odec_idx); end
        #2 ireset = 1'b1;
        #1;
        compared++;
        if (oval !== 1'b0) begin mismatched++; $display("FAIL rst_async_val: got %b want 0", oval); end
        compared++;
        if (obs_beat() !== '0 || {obusy, oovf} !== 2'b00)
            begin mismatched++; $display("FAIL rst_async_out: got %h %b%b want 0", obs_beat(), obusy, oovf); end
        fq_bank.delete(); fq_ptr.delete(); k = 0; ovf_exp = 1'b0;
        @(posedge iclk);
        #1 ireset = 1'b0;
        repeat (4) begin
            compared++;
            if (oval !== 1'b0) begin mismatched++; $display("FAIL rst_quiet: got oval=%b want 0", oval); end
            tick(1'b0, 1'b0, '0, 1'b1);
        end
        tick(1'b1, 1'b0, rand_bank(DN'(16'h8001)), 1'b1);
        for (int cyc = 0; cyc < 60 && fq_ptr.size() != 0; cyc++) begin
            if (oval === 1'b1) begin
                compared++;
                if (obs_beat() !== exp_beat())
                    begin mismatched++; $display("FAIL rst_beat: got %h want %h", obs_beat(), exp_beat()); end
                nb++;
            end
            tick(1'b0, 1'b0, '0, 1'b1);
        end
        compared++;
        if (nb != DN) begin mismatched++; $display("FAIL rst_count: got %0d want %0d", nb, DN); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_zero_detect();
        test_backpressure();
        test_back_to_back();
        test_clkena();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
